// File: rtl/immgen_stage_if.sv
// Valid/ready bundle for the IF/ID immediate-generation stage: upstream instruction
// handshake plus the downstream decoded entry.
interface immgen_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;

    logic            out_valid_o;
    logic            out_ready_i;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] imm_o;
    logic [2:0]      fmt_o;
    logic            illegal_o;

    // Environment side: fetch drives instructions in, decode consumes entries.
    modport master (
        output in_valid_i, instr_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, instr_o, pc_o, imm_o, fmt_o, illegal_o
    );

    // Stage side.
    modport slave (
        input  in_valid_i, instr_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, instr_o, pc_o, imm_o, fmt_o, illegal_o
    );
endinterface

// File: rtl/immgen_stage.sv
// IF/ID stage: decodes the immediate of an RV32I/RV64I instruction on accept and holds
// {instr, pc, imm, fmt, illegal} in a valid/ready register or a 2-entry skid buffer.
module immgen_stage #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1,
    parameter bit CSR_EN  = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    immgen_stage_if.slave bus
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("immgen_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_Z     = 3'd6,
        FMT_SHAMT = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    // ------------------------------------------------------------------
    // Immediate decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [31:0]     ins;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt, imm_z;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_ill;
    entry_t          dec_entry;

    assign ins = bus.instr_i;

    // Replication counts stay positive for both widths by keeping bit 31 in the fill.
    assign imm_i     = {{(XLEN-12){ins[31]}}, ins[31:20]};
    assign imm_s     = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b     = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u     = {{(XLEN-31){ins[31]}}, ins[30:12], 12'h000};
    assign imm_j     = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_shamt = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
    assign imm_z     = XLEN'(ins[19:15]);

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (ins[6:0])
            OPC_LOAD, OPC_JALR: begin
                dec_imm = imm_i;
                dec_fmt = FMT_I;
            end
            OPC_OP_IMM: begin
                // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount
                if (ins[13:12] == 2'b01) begin
                    dec_imm = imm_shamt;
                    dec_fmt = FMT_SHAMT;
                end else begin
                    dec_imm = imm_i;
                    dec_fmt = FMT_I;
                end
            end
            OPC_STORE: begin
                dec_imm = imm_s;
                dec_fmt = FMT_S;
            end
            OPC_BRANCH: begin
                dec_imm = imm_b;
                dec_fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_imm = imm_u;
                dec_fmt = FMT_U;
            end
            OPC_JAL: begin
                dec_imm = imm_j;
                dec_fmt = FMT_J;
            end
            OPC_OP: begin
                dec_fmt = FMT_NONE;
            end
            OPC_SYSTEM: begin
                if (CSR_EN) begin
                    if (ins[14]) begin
                        dec_imm = imm_z;
                        dec_fmt = FMT_Z;
                    end else begin
                        dec_imm = imm_i;
                        dec_fmt = FMT_I;
                    end
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    always_comb begin
        dec_entry         = '0;
        dec_entry.instr   = ins;
        dec_entry.pc      = bus.pc_i;
        dec_entry.imm     = dec_imm;
        dec_entry.fmt     = dec_fmt;
        dec_entry.illegal = dec_ill;
    end

    // ------------------------------------------------------------------
    // Storage: MAIN always feeds the outputs
    // ------------------------------------------------------------------
    entry_t main_q, main_d;
    logic   out_valid;
    logic   in_ready;

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.instr_o     = main_q.instr;
    assign bus.pc_o        = main_q.pc;
    assign bus.imm_o       = main_q.imm;
    assign bus.fmt_o       = main_q.fmt;
    assign bus.illegal_o   = main_q.illegal;

    generate
        if (SKID_EN) begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_TWO   = 2'd2
            } state_e;

            state_e state_q, state_d;
            entry_t skid_q, skid_d;
            logic   in_ready_q, in_ready_d;
            logic   push, pop;

            assign in_ready  = in_ready_q;
            assign out_valid = (state_q != ST_EMPTY);
            assign push      = bus.in_valid_i && in_ready_q;
            assign pop       = out_valid && bus.out_ready_i;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush_i) begin
                    state_d = ST_EMPTY;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (push) begin
                                main_d  = dec_entry;
                                state_d = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (push && pop) begin
                                main_d = dec_entry;
                            end else if (push) begin
                                skid_d  = dec_entry;
                                state_d = ST_TWO;
                            end else if (pop) begin
                                state_d = ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (pop) begin
                                main_d  = skid_q;
                                state_d = ST_ONE;
                            end
                        end
                        default: begin
                            state_d = ST_EMPTY;
                        end
                    endcase
                end
                // Registered ready: looks at next state so there is no path from out_ready_i
                in_ready_d = (state_d != ST_TWO);
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_q    <= ST_EMPTY;
                    main_q     <= '0;
                    skid_q     <= '0;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    main_q     <= main_d;
                    skid_q     <= skid_d;
                    in_ready_q <= in_ready_d;
                end
            end
        end else begin : g_single
            logic valid_q, valid_d;

            assign out_valid = valid_q;
            assign in_ready  = !valid_q || bus.out_ready_i;

            always_comb begin
                valid_d = valid_q;
                main_d  = main_q;
                if (flush_i) begin
                    valid_d = 1'b0;
                end else if (bus.in_valid_i && in_ready) begin
                    main_d  = dec_entry;
                    valid_d = 1'b1;
                end else if (bus.out_ready_i) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    main_q  <= main_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_immgen_stage.sv
// Bench for immgen_stage: three configurations (RV32 skid, RV64 skid, RV32 single/no CSR)
// against a queue-based scoreboard, a table of known encodings and hand-built sequences.
module tb_immgen_stage;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        bit          ill;
    } exp_t;

    typedef struct {
        int          d;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        bit          ill;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [2:0]  iv, ordy, fl, ir, ov, oill;
    logic [31:0] ins   [3];
    logic [63:0] pcv   [3];
    logic [31:0] oinstr[3];
    logic [63:0] opc   [3];
    logic [63:0] oimm  [3];
    logic [2:0]  ofmt  [3];

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 0;
    exp_t expq[3][$];
    vec_t vecs[15];

    immgen_stage_if #(.XLEN(32)) if0 ();
    immgen_stage_if #(.XLEN(64)) if1 ();
    immgen_stage_if #(.XLEN(32)) if2 ();

    immgen_stage #(.XLEN(32), .SKID_EN(1'b1), .CSR_EN(1'b1)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[0]), .bus(if0.slave));
    immgen_stage #(.XLEN(64), .SKID_EN(1'b1), .CSR_EN(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[1]), .bus(if1.slave));
    immgen_stage #(.XLEN(32), .SKID_EN(1'b0), .CSR_EN(1'b0)) dut2 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[2]), .bus(if2.slave));

    assign if0.in_valid_i  = iv[0];
    assign if0.instr_i     = ins[0];
    assign if0.pc_i        = pcv[0][31:0];
    assign if0.out_ready_i = ordy[0];
    assign ir[0]     = if0.in_ready_o;
    assign ov[0]     = if0.out_valid_o;
    assign oinstr[0] = if0.instr_o;
    assign opc[0]    = {32'h0, if0.pc_o};
    assign oimm[0]   = {32'h0, if0.imm_o};
    assign ofmt[0]   = if0.fmt_o;
    assign oill[0]   = if0.illegal_o;

    assign if1.in_valid_i  = iv[1];
    assign if1.instr_i     = ins[1];
    assign if1.pc_i        = pcv[1];
    assign if1.out_ready_i = ordy[1];
    assign ir[1]     = if1.in_ready_o;
    assign ov[1]     = if1.out_valid_o;
    assign oinstr[1] = if1.instr_o;
    assign opc[1]    = if1.pc_o;
    assign oimm[1]   = if1.imm_o;
    assign ofmt[1]   = if1.fmt_o;
    assign oill[1]   = if1.illegal_o;

    assign if2.in_valid_i  = iv[2];
    assign if2.instr_i     = ins[2];
    assign if2.pc_i        = pcv[2][31:0];
    assign if2.out_ready_i = ordy[2];
    assign ir[2]     = if2.in_ready_o;
    assign ov[2]     = if2.out_valid_o;
    assign oinstr[2] = if2.instr_o;
    assign opc[2]    = {32'h0, if2.pc_o};
    assign oimm[2]   = {32'h0, if2.imm_o};
    assign ofmt[2]   = if2.fmt_o;
    assign oill[2]   = if2.illegal_o;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode straight from the ISA immediate definitions.
    function automatic exp_t model(input int d, input logic [31:0] x, input logic [63:0] p);
        exp_t   e;
        longint v;
        int     xl;
        xl      = (d == 1) ? 64 : 32;
        v       = 0;
        e.instr = x;
        e.fmt   = 3'd0;
        e.ill   = 0;
        case (x[6:0])
            7'h03, 7'h67: begin v = $signed(x[31:20]); e.fmt = 3'd1; end
            7'h13: begin
                if (x[13:12] == 2'b01) begin
                    v = (xl == 64) ? longint'(x[25:20]) : longint'(x[24:20]);
                    e.fmt = 3'd7;
                end else begin
                    v = $signed(x[31:20]); e.fmt = 3'd1;
                end
            end
            7'h23: begin v = $signed({x[31:25], x[11:7]}); e.fmt = 3'd2; end
            7'h63: begin v = $signed({x[31], x[7], x[30:25], x[11:8], 1'b0}); e.fmt = 3'd3; end
            7'h37, 7'h17: begin v = $signed({x[31:12], 12'h000}); e.fmt = 3'd4; end
            7'h6F: begin v = $signed({x[31], x[19:12], x[20], x[30:21], 1'b0}); e.fmt = 3'd5; end
            7'h33: begin v = 0; end
            7'h73: begin
                if (d == 2) e.ill = 1;
                else if (x[14]) begin v = longint'(x[19:15]); e.fmt = 3'd6; end
                else begin v = $signed(x[31:20]); e.fmt = 3'd1; end
            end
            default: e.ill = 1;
        endcase
        if (xl == 32) begin
            e.imm = {32'h0, v[31:0]};
            e.pc  = {32'h0, p[31:0]};
        end else begin
            e.imm = v;
            e.pc  = p;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 10))
            0: r[6:0] = 7'h03;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h17;
            3: r[6:0] = 7'h23;  4: r[6:0] = 7'h33;  5: r[6:0] = 7'h37;
            6: r[6:0] = 7'h63;  7: r[6:0] = 7'h67;  8: r[6:0] = 7'h6F;
            9: r[6:0] = 7'h73;  default: ;
        endcase
        return r;
    endfunction

    // Scoreboard: checks the held entry against the queue head, then applies this edge's handshakes.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                int n;
                n = expq[d].size();
                if (rst) begin
                    expq[d].delete();
                end else begin
                    chk($sformatf("d%0d out_valid", d), ov[d], n > 0);
                    if (n > 0) begin
                        chk($sformatf("d%0d instr", d), oinstr[d], expq[d][0].instr);
                        chk($sformatf("d%0d pc", d), opc[d], expq[d][0].pc);
                        chk($sformatf("d%0d imm", d), oimm[d], expq[d][0].imm);
                        chk($sformatf("d%0d fmt", d), ofmt[d], expq[d][0].fmt);
                        chk($sformatf("d%0d illegal", d), oill[d], expq[d][0].ill);
                    end
                    chk($sformatf("d%0d in_ready", d), ir[d],
                        (d == 2) ? (n == 0 || ordy[d]) : (n < 2));
                    if (fl[d]) begin
                        expq[d].delete();
                    end else begin
                        if (ov[d] && ordy[d] && n > 0) void'(expq[d].pop_front());
                        if (iv[d] && ir[d]) expq[d].push_back(model(d, ins[d], pcv[d]));
                    end
                end
            end
        end
    end

    task automatic push(input int d, input logic [31:0] x, input logic [63:0] p);
        int k;
        k = 0;
        while (!ir[d] && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk($sformatf("d%0d push ready", d), ir[d], 1);
        iv[d]  = 1'b1;
        ins[d] = x;
        pcv[d] = p;
        @(posedge clk); #1;
        iv[d] = 1'b0;
    endtask

    initial begin
        clk  = 0;
        rst  = 1;
        iv   = '0;
        ordy = '0;
        fl   = '0;
        for (int d = 0; d < 3; d++) begin
            ins[d] = '0;
            pcv[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 0;
        mon_en = 1;

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d reset out_valid", d), ov[d], 0);
            chk($sformatf("d%0d reset in_ready", d), ir[d], 1);
            chk($sformatf("d%0d reset instr", d), oinstr[d], 0);
            chk($sformatf("d%0d reset pc", d), opc[d], 0);
            chk($sformatf("d%0d reset imm", d), oimm[d], 0);
            chk($sformatf("d%0d reset fmt", d), ofmt[d], 0);
            chk($sformatf("d%0d reset illegal", d), oill[d], 0);
        end

        vecs[0]  = '{0, 32'h12345037, 64'h12345000, 3'd4, 0};
        vecs[1]  = '{0, 32'hFE000EE3, 64'hFFFFFFFC, 3'd3, 0};
        vecs[2]  = '{0, 32'h0080006F, 64'h8, 3'd5, 0};
        vecs[3]  = '{0, 32'h3401D073, 64'h3, 3'd6, 0};
        vecs[4]  = '{0, 32'h0000000B, 64'h0, 3'd0, 1};
        vecs[5]  = '{0, 32'hFFF00093, 64'hFFFFFFFF, 3'd1, 0};
        vecs[6]  = '{0, 32'hFE20AC23, 64'hFFFFFFF8, 3'd2, 0};
        vecs[7]  = '{0, 32'h002081B3, 64'h0, 3'd0, 0};
        vecs[8]  = '{0, 32'h02D09093, 64'hD, 3'd7, 0};
        vecs[9]  = '{1, 32'h02D09093, 64'd45, 3'd7, 0};
        vecs[10] = '{1, 32'h80000037, 64'hFFFFFFFF80000000, 3'd4, 0};
        vecs[11] = '{1, 32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 0};
        vecs[12] = '{1, 32'h300020F3, 64'h300, 3'd1, 0};
        vecs[13] = '{2, 32'h3401D073, 64'h0, 3'd0, 1};
        vecs[14] = '{2, 32'h12345037, 64'h12345000, 3'd4, 0};

        ordy = '1;
        foreach (vecs[i]) begin
            push(vecs[i].d, vecs[i].instr, 64'h1000 + 64'(4 * i));
            chk($sformatf("vec%0d out_valid", i), ov[vecs[i].d], 1);
            chk($sformatf("vec%0d instr", i), oinstr[vecs[i].d], vecs[i].instr);
            chk($sformatf("vec%0d imm", i), oimm[vecs[i].d], vecs[i].imm);
            chk($sformatf("vec%0d fmt", i), ofmt[vecs[i].d], vecs[i].fmt);
            chk($sformatf("vec%0d illegal", i), oill[vecs[i].d], vecs[i].ill);
            @(posedge clk); #1;
        end

        // Backpressure: A and B fill the skid, C waits, release drains in order.
        ordy[0] = 0;
        push(0, 32'h00001037, 64'h100);
        push(0, 32'h00002037, 64'h104);
        chk("bp full in_ready", ir[0], 0);
        chk("bp full instr", oinstr[0], 32'h00001037);
        iv[0] = 1; ins[0] = 32'h00003037; pcv[0] = 64'h108;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp hold instr", oinstr[0], 32'h00001037);
            chk("bp hold in_ready", ir[0], 0);
        end
        ordy[0] = 1;
        @(posedge clk); #1;
        chk("bp release instr", oinstr[0], 32'h00002037);
        chk("bp release in_ready", ir[0], 1);
        @(posedge clk); #1;
        iv[0] = 0;
        chk("bp third instr", oinstr[0], 32'h00003037);
        @(posedge clk); #1;

        // Flush while full with a push in the same cycle.
        ordy[0] = 0;
        push(0, 32'h00004037, 64'h200);
        push(0, 32'h00005037, 64'h204);
        iv[0] = 1; ins[0] = 32'h00006037; fl[0] = 1;
        @(posedge clk); #1;
        iv[0] = 0; fl[0] = 0;
        chk("flush out_valid", ov[0], 0);
        chk("flush in_ready", ir[0], 1);
        ordy[0] = 1;
        repeat (3) @(posedge clk);
        #1;

        // Reset while full.
        ordy[0] = 0;
        push(0, 32'h00007037, 64'h300);
        push(0, 32'h00008037, 64'h304);
        chk("rst2 pre in_ready", ir[0], 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst2 out_valid", ov[0], 0);
        chk("rst2 in_ready", ir[0], 1);
        chk("rst2 imm", oimm[0], 0);
        chk("rst2 instr", oinstr[0], 0);
        ordy[0] = 1;

        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 3; d++) begin
                iv[d]   = ($urandom_range(0, 9) < 7);
                ins[d]  = rand_instr();
                pcv[d]  = {$urandom(), $urandom()};
                ordy[d] = ($urandom_range(0, 9) < 6);
                fl[d]   = ($urandom_range(0, 39) == 0);
            end
            @(posedge clk); #1;
        end

        iv = '0; fl = '0; ordy = '1;
        repeat (5) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d drained", d), ov[d], 0);
            chk($sformatf("d%0d model empty", d), expq[d].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
